// File: rtl/sd_pkg.sv
// sd_pkg: shared SD host definitions.
// Holds the SD command indices used by the read sequencer, the final status
// codes reported to software, the status encodings returned by sd_data_rx,
// and a helper that builds the CMD23 block-count argument.
package sd_pkg;

  // SD command indices
  localparam logic [5:0] SD_CMD_STOP        = 6'd12;
  localparam logic [5:0] SD_CMD_READ_SINGLE = 6'd17;
  localparam logic [5:0] SD_CMD_READ_MULTI  = 6'd18;
  localparam logic [5:0] SD_CMD_SET_COUNT   = 6'd23;

  // Final status codes reported with the completion interrupt
  localparam logic [2:0] FINAL_OK         = 3'd0;
  localparam logic [2:0] FINAL_RX_TIMEOUT = 3'd1;
  localparam logic [2:0] FINAL_END_BIT    = 3'd2;
  localparam logic [2:0] FINAL_CRC        = 3'd3;
  localparam logic [2:0] FINAL_CMD_ERR    = 3'd4;

  // Status encodings returned by sd_data_rx
  localparam logic [1:0] RX_OK      = 2'd0;
  localparam logic [1:0] RX_TIMEOUT = 2'd1;
  localparam logic [1:0] RX_END_BIT = 2'd2;
  localparam logic [1:0] RX_CRC     = 2'd3;

  // CMD23 wants the real block count. The add is done in 17 bits so a
  // request of 0xFFFF blocks-minus-one becomes 0x10000 rather than wrapping.
  function automatic logic [31:0] setCountArg(input logic [15:0] blocksM1);
    return {15'b0, ({1'b0, blocksM1} + 17'd1)};
  endfunction

endpackage

// File: rtl/sd_cmd_issue.sv
// sd_cmd_issue: valid/accept/done tracker for one command-engine request.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start_i              one-cycle pulse: launch a command with index_i/arg_i
//   index_i, arg_i       command index and argument captured on start_i
//   cmd_accept_i         engine has taken the request
//   cmd_done_i           engine reports the response
//   cmd_valid_o          registered request, held until accepted
//   cmd_index_o          registered command index
//   cmd_arg_o            registered command argument
//   done_o               cmd_done_i qualified by a prior or same-cycle accept
module sd_cmd_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [5:0]  index_i,
  input  logic [31:0] arg_i,
  input  logic        cmd_accept_i,
  input  logic        cmd_done_i,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic        done_o
);

  logic        valid_q, valid_d;
  logic        accepted_q, accepted_d;
  logic [5:0]  index_q, index_d;
  logic [31:0] arg_q, arg_d;
  logic        acceptNow;

  assign acceptNow   = valid_q && cmd_accept_i;
  // A response may land in the same cycle as the accept.
  assign done_o      = cmd_done_i && (accepted_q || acceptNow);
  assign cmd_valid_o = valid_q;
  assign cmd_index_o = index_q;
  assign cmd_arg_o   = arg_q;

  // Next-state: a start loads a fresh request; otherwise track accept and
  // forget the accept once its done has been consumed so a stray done on the
  // next command's first cycle is not honoured.
  always_comb begin
    valid_d    = valid_q;
    accepted_d = accepted_q;
    index_d    = index_q;
    arg_d      = arg_q;
    if (start_i) begin
      valid_d    = 1'b1;
      accepted_d = 1'b0;
      index_d    = index_i;
      arg_d      = arg_i;
    end else begin
      if (acceptNow) begin
        valid_d    = 1'b0;
        accepted_d = 1'b1;
      end
      if (done_o) begin
        accepted_d = 1'b0;
      end
    end
  end

  // Request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      accepted_q <= 1'b0;
      index_q    <= 6'd0;
      arg_q      <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      accepted_q <= accepted_d;
      index_q    <= index_d;
      arg_q      <= arg_d;
    end
  end

endmodule

// File: rtl/sd_rd_sequencer.sv
// sd_rd_sequencer: runs a complete SD block read for software.
// Issues CMD23/CMD17/CMD18/CMD12 through the command engine, arms sd_data_rx
// with rx_pending/rx_trigger, collects the RX completion and retries failed
// attempts up to MAX_RETRIES extra times, then raises one interrupt.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   req_valid/lba/blocks_m1/words_len  software request (ignored while busy)
//   busy, done_irq, irq_clear      request status and level interrupt
//   final_status, retries_used     result of the last request
//   cmd_valid/index/arg            command request to the command engine
//   cmd_accept/done/err            command engine handshake and response
//   rx_pending, rx_trigger         arming of sd_data_rx
//   rx_words_len, rx_blocks_len_m1 latched transfer geometry for sd_data_rx
//   rx_status, rx_ack              RX completion status and toggle
module sd_rd_sequencer #(
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_lba,
  input  logic [15:0] req_blocks_m1,
  input  logic [7:0]  req_words_len,
  output logic        busy,
  output logic        done_irq,
  input  logic        irq_clear,
  output logic [2:0]  final_status,
  output logic [1:0]  retries_used,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  input  logic        cmd_accept,
  input  logic        cmd_done,
  input  logic        cmd_err,
  output logic        rx_pending,
  output logic        rx_trigger,
  output logic [7:0]  rx_words_len,
  output logic [15:0] rx_blocks_len_m1,
  input  logic [1:0]  rx_status,
  input  logic        rx_ack
);
  import sd_pkg::*;

  localparam logic [1:0] MaxRetries = 2'(MAX_RETRIES);

  typedef enum logic [3:0] {
    S_IDLE, S_SETCNT, S_ARM, S_CMD_RD, S_WAIT_RX,
    S_STOP, S_RETRY, S_FAIL_CMD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        entry_q;
  logic        busy_q, busy_d;
  logic        doneIrq_q, doneIrq_d;
  logic [2:0]  finalStatus_q, finalStatus_d;
  logic [1:0]  retriesUsed_q, retriesUsed_d;
  logic        rxPending_q, rxPending_d;
  logic        rxTrigger_q, rxTrigger_d;
  logic [31:0] lba_q, lba_d;
  logic [15:0] blocksM1_q, blocksM1_d;
  logic [7:0]  wordsLen_q, wordsLen_d;
  logic [1:0]  retryCnt_q, retryCnt_d;
  logic        ackSeen_q, ackSeen_d;
  logic [1:0]  rxStatus_q, rxStatus_d;
  logic [2:0]  pendStatus_q, pendStatus_d;

  logic        multiBlk;
  logic        cmdStart;
  logic        cmdDoneOk;
  logic [5:0]  issueIndex;
  logic [31:0] issueArg;

  assign multiBlk = (blocksM1_q != 16'd0);

  // Commands launch on the first cycle spent in a command state, so
  // cmd_valid appears one cycle after the state is entered.
  assign cmdStart = entry_q &&
                    ((state_q == S_SETCNT) || (state_q == S_CMD_RD) || (state_q == S_STOP));

  // Select the command the current state wants to send.
  always_comb begin
    issueIndex = 6'd0;
    issueArg   = 32'd0;
    case (state_q)
      S_SETCNT: begin
        issueIndex = SD_CMD_SET_COUNT;
        issueArg   = setCountArg(blocksM1_q);
      end
      S_CMD_RD: begin
        issueIndex = multiBlk ? SD_CMD_READ_MULTI : SD_CMD_READ_SINGLE;
        issueArg   = lba_q;
      end
      S_STOP: begin
        issueIndex = SD_CMD_STOP;
        issueArg   = 32'd0;
      end
      default: ;
    endcase
  end

  sd_cmd_issue u_cmdIssue (
    .clk          (clk),
    .reset        (reset),
    .start_i      (cmdStart),
    .index_i      (issueIndex),
    .arg_i        (issueArg),
    .cmd_accept_i (cmd_accept),
    .cmd_done_i   (cmd_done),
    .cmd_valid_o  (cmd_valid),
    .cmd_index_o  (cmd_index),
    .cmd_arg_o    (cmd_arg),
    .done_o       (cmdDoneOk)
  );

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    doneIrq_d     = doneIrq_q;
    finalStatus_d = finalStatus_q;
    retriesUsed_d = retriesUsed_q;
    rxPending_d   = rxPending_q;
    rxTrigger_d   = 1'b0;
    lba_d         = lba_q;
    blocksM1_d    = blocksM1_q;
    wordsLen_d    = wordsLen_q;
    retryCnt_d    = retryCnt_q;
    ackSeen_d     = ackSeen_q;
    rxStatus_d    = rxStatus_q;
    pendStatus_d  = pendStatus_q;

    if (irq_clear) begin
      doneIrq_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lba_d      = req_lba;
          blocksM1_d = req_blocks_m1;
          wordsLen_d = req_words_len;
          retryCnt_d = 2'd0;
          busy_d     = 1'b1;
          state_d    = (req_blocks_m1 != 16'd0) ? S_SETCNT : S_ARM;
        end
      end
      S_SETCNT: begin
        if (cmdDoneOk) begin
          state_d = cmd_err ? S_FAIL_CMD : S_ARM;
        end
      end
      S_ARM: begin
        rxPending_d = 1'b1;
        state_d     = S_CMD_RD;
      end
      S_CMD_RD: begin
        if (cmdDoneOk) begin
          if (cmd_err) begin
            rxPending_d = 1'b0;
            state_d     = S_FAIL_CMD;
          end else begin
            rxTrigger_d = 1'b1;
            state_d     = S_WAIT_RX;
          end
        end
      end
      S_WAIT_RX: begin
        // rx_ack is a toggle; any difference from the last seen level is a
        // new completion.
        if (rx_ack != ackSeen_q) begin
          ackSeen_d   = rx_ack;
          rxStatus_d  = rx_status;
          rxPending_d = 1'b0;
          if (rx_status == RX_OK) begin
            pendStatus_d = FINAL_OK;
            state_d      = S_DONE;
          end else begin
            state_d = multiBlk ? S_STOP : S_RETRY;
          end
        end
      end
      S_STOP: begin
        // The stop response is only used as a pacing point; errors on it do
        // not change the outcome of the attempt.
        if (cmdDoneOk) begin
          state_d = S_RETRY;
        end
      end
      S_RETRY, S_FAIL_CMD: begin
        if (retryCnt_q < MaxRetries) begin
          retryCnt_d = retryCnt_q + 2'd1;
          state_d    = multiBlk ? S_SETCNT : S_ARM;
        end else begin
          pendStatus_d = (state_q == S_FAIL_CMD) ? FINAL_CMD_ERR : {1'b0, rxStatus_q};
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        // Setting the interrupt here overrides a coincident irq_clear.
        finalStatus_d = pendStatus_q;
        retriesUsed_d = retryCnt_q;
        doneIrq_d     = 1'b1;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      entry_q       <= 1'b0;
      busy_q        <= 1'b0;
      doneIrq_q     <= 1'b0;
      finalStatus_q <= 3'd0;
      retriesUsed_q <= 2'd0;
      rxPending_q   <= 1'b0;
      rxTrigger_q   <= 1'b0;
      lba_q         <= 32'd0;
      blocksM1_q    <= 16'd0;
      wordsLen_q    <= 8'd0;
      retryCnt_q    <= 2'd0;
      ackSeen_q     <= 1'b0;
      rxStatus_q    <= 2'd0;
      pendStatus_q  <= 3'd0;
    end else begin
      state_q       <= state_d;
      entry_q       <= (state_d != state_q);
      busy_q        <= busy_d;
      doneIrq_q     <= doneIrq_d;
      finalStatus_q <= finalStatus_d;
      retriesUsed_q <= retriesUsed_d;
      rxPending_q   <= rxPending_d;
      rxTrigger_q   <= rxTrigger_d;
      lba_q         <= lba_d;
      blocksM1_q    <= blocksM1_d;
      wordsLen_q    <= wordsLen_d;
      retryCnt_q    <= retryCnt_d;
      ackSeen_q     <= ackSeen_d;
      rxStatus_q    <= rxStatus_d;
      pendStatus_q  <= pendStatus_d;
    end
  end

  assign busy             = busy_q;
  assign done_irq         = doneIrq_q;
  assign final_status     = finalStatus_q;
  assign retries_used     = retriesUsed_q;
  assign rx_pending       = rxPending_q;
  assign rx_trigger       = rxTrigger_q;
  assign rx_words_len     = wordsLen_q;
  assign rx_blocks_len_m1 = blocksM1_q;

endmodule
